// File: rtl/uart_tx_fifo_8n1.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer with a built-in baud divider.
// Frames are sent back-to-back while the FIFO holds data; tx idles high.
module uart_tx_fifo_8n1 #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  hwclk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CNT_W  = $clog2(DIV);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CW-1:0]    DEPTH_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_next;

  logic [1:0]            state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;

  logic push;
  logic pop;
  logic baud_end;

  assign push     = wr_en & ~full;
  assign baud_end = (baud_cnt == BAUD_LAST);
  // The FIFO is popped either from IDLE or at the last cycle of STOP, so frames chain without a gap.
  assign pop      = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_end));
  assign busy     = (state != ST_IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge hwclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // tx is always the registered output of the state machine; the shift register's
  // LSB is the data bit currently on the line during DATA.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_8n1.sv
// Bench for uart_tx_fifo_8n1: a DIV=16 instance driven by directed/random steps and decoded
// by a line-level UART receiver model, plus a default-parameter instance for bit-period timing.
module tb_uart_tx_fifo_8n1;

  localparam int DIV   = 16;
  localparam int DIV_D = 1250;

  logic       hwclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, empty, overflow, busy, tx;
  logic [4:0] count;

  logic [7:0] wr_data2 = 8'h00;
  logic       wr_en2 = 1'b0;
  logic       full2, empty2, overflow2, busy2, tx2;
  logic [4:0] count2;

  uart_tx_fifo_8n1 #(.CLK_HZ(16), .BAUD(1), .DEPTH_LOG2(4)) dut (
    .hwclk(hwclk), .reset_n(reset_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx(tx)
  );

  uart_tx_fifo_8n1 dut_def (
    .hwclk(hwclk), .reset_n(reset_n), .wr_data(wr_data2), .wr_en(wr_en2),
    .full(full2), .empty(empty2), .count(count2), .overflow(overflow2),
    .busy(busy2), .tx(tx2)
  );

  always #5 hwclk = ~hwclk;

  int unsigned cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Monitors: counters and queues only ever appended to here, read by the main sequence.
  int unsigned busy_cyc = 0;
  int unsigned busy2_cyc = 0;
  int unsigned ovf_cnt = 0;
  int unsigned frame_err = 0;
  logic        tx2_prev = 1'b1;
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];
  int unsigned tr_q[$];
  logic [7:0]  exp_q[$];

  always @(negedge hwclk) begin
    if (busy) busy_cyc <= busy_cyc + 1;
    if (busy2) busy2_cyc <= busy2_cyc + 1;
    if (overflow) ovf_cnt <= ovf_cnt + 1;
    if (tx2 !== tx2_prev) tr_q.push_back(cyc);
    tx2_prev <= tx2;
  end

  // Receiver model: a low level seen at a negedge marks the start bit; each bit is sampled mid-period.
  initial begin
    logic [7:0] b;
    bit ok;
    bit aborted;
    int bi;
    forever begin
      @(negedge hwclk);
      if (reset_n && tx === 1'b0) begin
        start_q.push_back(cyc);
        b = 8'h00;
        ok = 1'b1;
        aborted = 1'b0;
        for (int p = 1; p < 10 * DIV; p++) begin
          @(negedge hwclk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          if (p % DIV == DIV / 2) begin
            bi = p / DIV;
            if (bi == 0) begin
              if (tx !== 1'b0) ok = 1'b0;
            end else if (bi <= 8) begin
              b[bi-1] = tx;
            end else if (tx !== 1'b1) begin
              ok = 1'b0;
            end
          end
        end
        if (!aborted) begin
          rx_q.push_back(b);
          if (!ok) frame_err = frame_err + 1;
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge hwclk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while ((busy || !empty) && n < lim) begin
      @(negedge hwclk);
      n++;
    end
    chk(tag, (n < lim), 1);
  endtask

  initial begin
    int unsigned b0, o0, s0, r0, wcyc;
    int n, lows, busies, nxt, burst, gap;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge hwclk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge hwclk);

    // Single byte 0x30 from idle
    b0 = busy_cyc;
    s0 = start_q.size();
    wcyc = cyc;
    wr(8'h30);
    exp_q.push_back(8'h30);
    chk("t1_count_after_write", count, 1);
    chk("t1_busy_before_pop", busy, 0);
    chk("t1_tx_before_pop", tx, 1);
    @(negedge hwclk);
    chk("t1_tx_start", tx, 0);
    chk("t1_busy_start", busy, 1);
    chk("t1_count_after_pop", count, 0);
    chk("t1_empty_after_pop", empty, 1);
    wait_idle("t1_idle_timeout", 1000);
    chk("t1_busy_cycles", busy_cyc - b0, 160);
    chk("t1_frames", start_q.size() - s0, 1);
    chk("t1_start_latency", start_q[s0] - wcyc, 2);
    chk("t1_byte", rx_q[rx_q.size()-1], 8'h30);

    // Three consecutive writes, back-to-back frames
    b0 = busy_cyc;
    s0 = start_q.size();
    wr(8'h31);
    wr(8'h32);
    wr(8'h0D);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h0D);
    chk("t2_count_peak", count, 2);
    wait_idle("t2_idle_timeout", 2000);
    chk("t2_busy_cycles", busy_cyc - b0, 480);
    chk("t2_frames", start_q.size() - s0, 3);
    chk("t2_gap01", start_q[s0+1] - start_q[s0], 160);
    chk("t2_gap12", start_q[s0+2] - start_q[s0+1], 160);

    // Fill to full, then one rejected write
    o0 = ovf_cnt;
    wr(8'h41);
    exp_q.push_back(8'h41);
    for (int k = 1; k < 17; k++) begin
      d = 8'($urandom);
      wr(d);
      exp_q.push_back(d);
    end
    chk("t3_count_full", count, 16);
    chk("t3_full", full, 1);
    wr(8'hEE);
    chk("t3_overflow_pulse", overflow, 1);
    chk("t3_count_after_drop", count, 16);
    @(negedge hwclk);
    chk("t3_overflow_clear", overflow, 0);
    wait_idle("t3_idle_timeout", 5000);
    chk("t3_overflow_total", ovf_cnt - o0, 1);
    chk("t3_rx_count", rx_q.size(), exp_q.size());

    // Reset during data bit 3 with 5 bytes queued
    r0 = rx_q.size();
    for (int k = 0; k < 6; k++) wr(8'($urandom));
    chk("t4_count_queued", count, 5);
    repeat (66) @(negedge hwclk);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_async_tx", tx, 1);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_count", count, 0);
    chk("t4_async_empty", empty, 1);
    repeat (3) @(negedge hwclk);
    reset_n = 1'b1;
    lows = 0;
    busies = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge hwclk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    chk("t4_tx_low_after_reset", lows, 0);
    chk("t4_busy_after_reset", busies, 0);
    chk("t4_no_rx", rx_q.size(), r0);

    // Stream 0x00..0x27 in random bursts keeping count below 16
    o0 = ovf_cnt;
    nxt = 0;
    while (nxt < 40) begin
      burst = $urandom_range(1, 5);
      if (nxt + burst > 40) burst = 40 - nxt;
      n = 0;
      while (int'(count) > 15 - burst && n < 5000) begin
        @(negedge hwclk);
        n++;
      end
      chk("t5_room_timeout", (n < 5000), 1);
      for (int k = 0; k < burst; k++) begin
        wr(8'(nxt));
        exp_q.push_back(8'(nxt));
        nxt++;
      end
      gap = $urandom_range(0, 40);
      repeat (gap) @(negedge hwclk);
    end
    wait_idle("t5_idle_timeout", 10000);
    chk("t5_overflow_none", ovf_cnt - o0, 0);

    // Whole transmitted sequence versus accepted writes
    chk("rx_total", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("rx_byte_%0d", i), rx_q[i], exp_q[i]);
    end
    chk("frame_errors", frame_err, 0);

    // Default parameters: 0x55 bit periods
    b0 = busy2_cyc;
    wr_en2 = 1'b1;
    wr_data2 = 8'h55;
    @(negedge hwclk);
    wr_en2 = 1'b0;
    n = 0;
    while ((busy2 || !empty2) && n < 20000) begin
      @(negedge hwclk);
      n++;
    end
    chk("t6_idle_timeout", (n < 20000), 1);
    chk("t6_busy_cycles", busy2_cyc - b0, 10 * DIV_D);
    chk("t6_transitions", tr_q.size(), 10);
    for (int i = 1; i < tr_q.size(); i++) begin
      chk($sformatf("t6_bit_period_%0d", i), tr_q[i] - tr_q[i-1], DIV_D);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
